// File: rtl/uart_pkt_gen_pkg.sv
// Shared definitions for the UART packet generator: state encodings, default command codes, bit period.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkt_gen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;

    localparam int DEF_WR_CMD = 'h44;
    localparam int DEF_RD_CMD = 'h55;

    function automatic int bit_cyc(input longint clk_freq, input longint baud_rate);
        return int'(clk_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle bit_tick every BIT_CYC cycles while en is high;
// dropping en restarts the count at zero.
module uart_baud_gen #(
    parameter int BIT_CYC = 10
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic bit_tick
);
    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign bit_tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/uart_pkt_gen.sv
// UART packet generator: READ = RD_CMD frame, WRITE = WR_CMD + BURST_LEN payload frames.
// Define UART_PARITY_EN to add a parity bit per frame (even, or odd with PARITY_ODD=1).
module uart_pkt_gen
    import uart_pkt_gen_pkg::*;
#(
    parameter int CLK_FREQ  = 200_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int D_WIDTH   = 8,
    parameter int BURST_LEN = 4,
    parameter int IDLE_BITS = 10,
    parameter logic [D_WIDTH-1:0] WR_CMD = D_WIDTH'(DEF_WR_CMD),
    parameter logic [D_WIDTH-1:0] RD_CMD = D_WIDTH'(DEF_RD_CMD)
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_is_rd,
    input  logic [D_WIDTH*BURST_LEN-1:0]   wr_data,
    output logic                           tx,
    output logic                           busy,
    output logic                           pkt_done
);
    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD_RATE);
    localparam int BW = $clog2(D_WIDTH);
    localparam int FW = $clog2(BURST_LEN + 1);
    localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

    state_t                         state_reg;
    logic                           tx_reg;
    logic                           busy_reg;
    logic                           cmd_ready_reg;
    logic                           is_rd_reg;
    logic [D_WIDTH*BURST_LEN-1:0]   wr_data_reg;
    logic [D_WIDTH-1:0]             shift_reg;
    logic [BW-1:0]                  bit_cnt_reg;
    logic [FW-1:0]                  frame_cnt_reg;
    logic [GW-1:0]                  gap_cnt_reg;
`ifdef UART_PARITY_EN
    logic                           parity_reg;
`endif

    logic                           bit_tick;
    logic                           last_frame;
    logic                           last_gap_bit;
    logic [D_WIDTH-1:0]             cmd_frame;
    logic [D_WIDTH-1:0]             payload [1<<FW];

    uart_baud_gen #(.BIT_CYC(BIT_CYC)) u_baud (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (busy_reg),
        .bit_tick  (bit_tick)
    );

    // Payload table padded to a power of two so frame_cnt_reg indexes it directly.
    for (genvar gi = 0; gi < (1 << FW); gi++) begin : g_payload
        if (gi < BURST_LEN) begin : g_used
            assign payload[gi] = wr_data_reg[gi*D_WIDTH +: D_WIDTH];
        end else begin : g_pad
            assign payload[gi] = '0;
        end
    end

    assign cmd_frame    = cmd_is_rd ? RD_CMD : WR_CMD;
    assign last_frame   = is_rd_reg ? (frame_cnt_reg == '0) : (frame_cnt_reg == FW'(BURST_LEN));
    assign last_gap_bit = (gap_cnt_reg == GW'(IDLE_BITS - 1));

    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign cmd_ready = cmd_ready_reg;
    // Decoded from registers so the pulse lands in the final GAP cycle, not one after it.
    assign pkt_done  = (state_reg == GAP) && last_frame && last_gap_bit && bit_tick;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
            cmd_ready_reg <= 1'b0;
            is_rd_reg     <= 1'b0;
            wr_data_reg   <= '0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
`ifdef UART_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        state_reg     <= START;
                        tx_reg        <= 1'b0;
                        busy_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        is_rd_reg     <= cmd_is_rd;
                        wr_data_reg   <= wr_data;
                        shift_reg     <= cmd_frame;
                        frame_cnt_reg <= '0;
`ifdef UART_PARITY_EN
                        parity_reg    <= (^cmd_frame) ^ PARITY_ODD;
`endif
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_reg   <= DATA;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[D_WIDTH-1:1]};
                        bit_cnt_reg <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_reg == BW'(D_WIDTH - 1)) begin
`ifdef UART_PARITY_EN
                            state_reg <= PARITY;
                            tx_reg    <= parity_reg;
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[D_WIDTH-1:1]};
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                    end
                end
                GAP: begin
                    if (bit_tick) begin
                        if (!last_gap_bit) begin
                            gap_cnt_reg <= gap_cnt_reg + GW'(1);
                        end else if (last_frame) begin
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                            cmd_ready_reg <= 1'b1;
                            frame_cnt_reg <= '0;
                        end else begin
                            // Payload frame k is table entry k, i.e. the current frame count.
                            state_reg     <= START;
                            tx_reg        <= 1'b0;
                            shift_reg     <= payload[frame_cnt_reg];
                            frame_cnt_reg <= frame_cnt_reg + FW'(1);
`ifdef UART_PARITY_EN
                            parity_reg    <= (^payload[frame_cnt_reg]) ^ PARITY_ODD;
`endif
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
